// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply/divide with built-in HI/LO result registers.
// Optional build macro MUL_DIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; operands and sign flags captured on start
// CALC  | one multiplier/quotient bit per cycle
// FIXUP | sign correction (and accumulator alignment after an early-terminated multiply)
// DONE  | results written to HI/LO, done pulses on the following cycle
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             hi_write,
    input  logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dzo_q, dzo_d;
`ifdef MUL_DIV_EARLY_TERM_EN
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [CW-1:0]        shamt;
`endif

    logic                 is_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum, rsh;
    logic [WIDTH-1:0]     diff;
    logic                 ge, last;
    logic [2*WIDTH-1:0]   acc_fix;

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dzo_d     = 1'b0;
        last      = 1'b0;
        acc_fix   = acc_q;
`ifdef MUL_DIV_EARLY_TERM_EN
        mplr_d    = mplr_q;
        shamt     = CW'(WIDTH) - cnt_q;
`endif

        is_signed = ~op[0];
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

        // multiply step: add multiplicand into the high half, then shift the whole accumulator right
        sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // divide step: partial remainder shifted left with the next dividend bit
        rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge   = rsh >= {1'b0, opb_q};
        diff = rsh[WIDTH-1:0] - opb_q;

        if (hi_write) hi_d = hi_in;
        if (lo_write) lo_d = lo_in;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed & a[WIDTH-1];
                    dz_d      = op[1] && (b == '0);
                    cnt_d     = '0;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        opb_d = mag_b;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                        opb_d = mag_a;
                    end
                    state_d = (op[1] && (b == '0)) ? S_DONE : S_CALC;
`ifdef MUL_DIV_EARLY_TERM_EN
                    mplr_d = mag_b;
                    if (!op[1] && (b == '0)) state_d = S_FIXUP;
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {(ge ? diff : rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                last = (cnt_q == LAST_CNT);
`ifdef MUL_DIV_EARLY_TERM_EN
                mplr_d = mplr_q >> 1;
                if (!is_div_q && (mplr_q[WIDTH-1:1] == '0)) last = 1'b1;
`endif
                if (last) state_d = S_FIXUP;
            end
            S_FIXUP: begin
`ifdef MUL_DIV_EARLY_TERM_EN
                // product bits still sit above the unconsumed shift positions
                if (!is_div_q) acc_fix = acc_q >> shamt;
`endif
                if (is_div_q) begin
                    acc_d[2*WIDTH-1:WIDTH] = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    acc_d[WIDTH-1:0]       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    acc_d = neg_res_q ? -acc_fix : acc_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    dzo_d = 1'b1;
                end else begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b0;
            dzo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dzo_q     <= 1'b0;
`ifdef MUL_DIV_EARLY_TERM_EN
            mplr_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dzo_q     <= dzo_d;
`ifdef MUL_DIV_EARLY_TERM_EN
            mplr_q    <= mplr_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dzo_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, hi_in = '0, lo_in = '0;
    logic         hi_write = 1'b0, lo_write = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] mhi = '0, mlo = '0;
    logic         mdz = 1'b0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .op(op),
        .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in),
        .hi_write(hi_write), .lo_write(lo_write),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        int r;
        r = W + 2;
        if (o[1] && y == '0) r = 1;
`ifdef MUL_DIV_EARLY_TERM_EN
        else if (!o[1]) begin
            logic [W-1:0] m;
            m = (o == 2'b00 && y[W-1]) ? -y : y;
            r = 2;
            for (int i = 0; i < W; i++) if (m[i]) r = i + 3;
        end
`endif
        return r;
    endfunction

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx  = o[0] ? longint'(x) : longint'($signed(x));
        sy  = o[0] ? longint'(y) : longint'($signed(y));
        mdz = 1'b0;
        if (!o[1]) begin
            p   = sx * sy;
            mhi = p[63:32];
            mlo = p[31:0];
        end else if (y == '0) begin
            mdz = 1'b1;
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            mlo = q[31:0];
            mhi = r[31:0];
        end
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = 0;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        model(o, x, y);
    endtask

    task automatic check_result(input string tag, input int lat, input int want);
        check({tag, "_lat"}, 64'(lat), 64'(want));
        check({tag, "_hi"}, hi_out, mhi);
        check({tag, "_lo"}, lo_out, mlo);
        check({tag, "_dz"}, div_by_zero, mdz);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int lat, want;
        want = exp_lat(o, y);
        issue(o, x, y);
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(200, lat);
        check_result(tag, lat, want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, want, seen;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_by_zero, 1'b0);
        check("rst_hi", hi_out, '0);
        check("rst_lo", lo_out, '0);
        @(negedge clk) reset = 1'b1;

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, "mult_m3x7");
        check("mult_m3x7_hi_const", hi_out, 32'hFFFFFFFF);
        check("mult_m3x7_lo_const", lo_out, 32'hFFFFFFEB);
        run_op(2'b01, 32'hFFFFFFFF, 32'd2, "multu_max");
        check("multu_max_hi_const", hi_out, 32'h00000001);
        check("multu_max_lo_const", lo_out, 32'hFFFFFFFE);
        run_op(2'b00, 32'hFFFFFFFF, 32'd2, "mult_m1x2");
        check("mult_m1x2_hi_const", hi_out, 32'hFFFFFFFF);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        check("div_m7_2_lo_const", lo_out, 32'hFFFFFFFD);
        check("div_m7_2_hi_const", hi_out, 32'hFFFFFFFF);
        run_op(2'b11, 32'd7, 32'd2, "divu_7_2");
        check("divu_7_2_lo_const", lo_out, 32'd3);
        check("divu_7_2_hi_const", hi_out, 32'd1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        check("div_ovf_lo_const", lo_out, 32'h80000000);
        check("div_ovf_hi_const", hi_out, 32'd0);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, "div_7_m2");
        run_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, "div_m7_m2");
        run_op(2'b01, 32'h12345678, 32'd1, "multu_b1");
        check("multu_b1_lo_const", lo_out, 32'h12345678);
        run_op(2'b01, 32'h00000ABC, 32'd0, "multu_b0");
        run_op(2'b00, 32'h80000000, 32'h80000000, "mult_minmin");
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, "divu_max");

        // direct HI/LO writes, then a divide by zero must leave them untouched
        @(negedge clk);
        hi_write = 1'b1; hi_in = 32'h11; lo_write = 1'b1; lo_in = 32'h22;
        @(posedge clk); #1;
        hi_write = 1'b0; lo_write = 1'b0;
        mhi = 32'h11; mlo = 32'h22;
        check("dw_hi", hi_out, 32'h11);
        check("dw_lo", lo_out, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, "div_by0");
        check("div_by0_hi_const", hi_out, 32'h11);
        run_op(2'b11, 32'd9, 32'd0, "divu_by0");

        // start while busy is ignored
        want = exp_lat(2'b00, 32'h80000003);
        issue(2'b00, 32'd5, 32'h80000003);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b11; a = 32'd9; b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, lat);
        check_result("ign_start", lat + 5, want);

        // direct write while busy is visible, then overwritten at completion
        want = exp_lat(2'b01, 32'hF0000000);
        issue(2'b01, 32'h1234, 32'hF0000000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        hi_write = 1'b1; hi_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        hi_write = 1'b0;
        check("busy_wr_hi", hi_out, 32'hDEADBEEF);
        wait_done(200, lat);
        check_result("busy_wr", lat + 4, want);

        // direct write on the completing edge loses to the result
        issue(2'b01, 32'h3, 32'h80000001);
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        hi_write = 1'b1; hi_in = 32'hAAAAAAAA; lo_write = 1'b1; lo_in = 32'h55555555;
        @(posedge clk); #1;
        hi_write = 1'b0; lo_write = 1'b0;
        check("coll_done", done, 1'b1);
        check("coll_hi", hi_out, mhi);
        check("coll_lo", lo_out, mlo);

        // random ops against the model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = 32'($urandom);
            endcase
            run_op(ro, ra, rb, $sformatf("rnd%0d", i));
        end

        // clear aborts a divide: IDLE, HI/LO zero, no completion
        issue(2'b10, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk) clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        mhi = '0; mlo = '0;
        check("clr_busy", busy, 1'b0);
        check("clr_hi", hi_out, '0);
        check("clr_lo", lo_out, '0);
        check("clr_done", done, 1'b0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("clr_no_done", 64'(seen), 64'd0);
        run_op(2'b01, 32'd6, 32'd7, "post_clr");

        // asynchronous reset in the middle of a multiply
        issue(2'b01, 32'h77, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_hi", hi_out, '0);
        check("arst_lo", lo_out, '0);
        @(negedge clk) reset = 1'b1;
        mhi = '0; mlo = '0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("arst_no_done", 64'(seen), 64'd0);
        run_op(2'b00, 32'hFFFFFF00, 32'h0000FFFF, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide engine with built-in HI/LO result registers. It replaces the separate multiplier, divider and HI/LO blocks in the multicycle CPU datapath. It supports signed and unsigned MULT/DIV at any even WIDTH through one start/done handshake, and provides direct HI/LO writes for MTHI/MTLO.

Parameters:
WIDTH, 32, operand width in bits; even, 4 or more; HI/LO are each WIDTH bits.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
clear  input  1  synchronous clear; aborts any operation and zeroes HI/LO.
start  input  1  operation request; sampled only in IDLE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a  input  WIDTH  multiplicand or dividend.
b  input  WIDTH  multiplier or divisor.
hi_in  input  WIDTH  direct HI write data.
lo_in  input  WIDTH  direct LO write data.
hi_write  input  1  direct HI write enable.
lo_write  input  1  direct LO write enable.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse on completion.
div_by_zero  output  1  high with done when a DIV/DIVU had b=0.
hi_out  output  WIDTH  HI register.
lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div_by_zero, hi_out and lo_out are all 0.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On start=1, latch op, the magnitudes of a and b (signed ops only) and the sign flags; clear the iteration counter.
  - DIV/DIVU with b=0 goes directly to DONE with the dz flag set. Otherwise go to CALC.
- CALC: one bit per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After the counter reaches WIDTH-1, go to FIXUP.
- FIXUP, signed ops only:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend, so the quotient truncates toward zero.
  - Then go to DONE.
- DONE: write the results, pulse done=1 for one cycle, return to IDLE.
  - Multiply: HI=product[2W-1:W], LO=product[W-1:0].
  - Divide: HI=remainder, LO=quotient.
  - Divide by zero: HI/LO are unchanged and div_by_zero=1 in the same cycle as done.
- Latency, with start sampled at edge E:
  - Normal ops: HI/LO are valid and done=1 after edge E+WIDTH+2.
  - Divide by zero: after edge E+1.
- Signed overflow: DIV of the most-negative value by -1 gives LO=most-negative, HI=0, with no flag.
- start while busy=1 is ignored. Operands are latched at start, so a and b may change afterwards.
- Direct hi_write/lo_write:
  - Update the corresponding register on the next edge in any state.
  - If the DONE write lands in the same cycle, the DONE write wins.
  - A direct write issued while busy is therefore overwritten at completion.
- clear=1 has priority over everything:
  - Next edge: state=IDLE, HI/LO=0.
  - done and div_by_zero stay 0; no completion is signalled for the aborted operation.
- reset asserted mid-operation: outputs go to their reset values immediately; no done is produced.

Optional Feature:
MUL_DIV_EARLY_TERM_EN
- Defined:
  - Multiply ends CALC as soon as the remaining shifted multiplier bits are all zero. The accumulator is aligned by the remaining shift count in FIXUP.
  - Latency becomes (index of highest set bit of |b|)+3 edges; b=0 takes 2 edges.
  - Divide latency is unchanged.
- Undefined: all operations use fixed latency as specified above. busy/done semantics are identical in both builds.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done after 34 edges, HI=0xFFFFFFFF, LO=0xFFFFFFEB, div_by_zero=0.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE. MULT with the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via hi_write/lo_write, then DIV b=0 -> done and div_by_zero high one edge after start; HI=0x11, LO=0x22 unchanged.
- Start MULT, pulse start with different operands at cycle 5 -> ignored, original result delivered. Start DIV, assert clear at cycle 10 -> IDLE next edge, HI/LO=0, no done pulse.
- Drop reset to 0 mid-operation (asynchronous, between edges) -> busy, done, HI and LO all 0 immediately. With MUL_DIV_EARLY_TERM_EN, MULTU b=1 -> done after 3 edges, LO=a.
